flash_audio_reader: RTL and testbench

Sequences word reads from the external flash over its Avalon-MM read port and turns each 32-bit word into two 16-bit audio samples, one per sample_tick. It owns the word address: forward/reverse stepping, wrap-around inside a window and restart. The audio output path consumes its samples; keyboard control logic drives play, reverse and restart.

---
 rtl/flash_audio_reader_if.sv | 21 ++
 rtl/flash_audio_reader.sv | 163 ++++++++++++++++
 tb/tb_flash_audio_reader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_audio_reader_if.sv
// Avalon-MM read-only port between the audio reader and the external flash.
// Latency: none, wires only.
// Backpressure: the slave holds waitrequest=1 until it accepts a read.
interface flash_audio_reader_if;
   logic        read;
   logic [22:0] address;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic        readdatavalid;
   logic [31:0] readdata;

   modport master (
      output read, address, byteenable,
      input  waitrequest, readdatavalid, readdata
   );

   modport slave (
      input  read, address, byteenable,
      output waitrequest, readdatavalid, readdata
   );
endinterface

// File: rtl/flash_audio_reader.sv
// Fetches 32-bit flash words and plays each one out as two 16-bit samples, one per sample_tick.
// Latency: a sample appears one cycle after the tick; a word fetch needs at least three cycles.
// Backpressure: read/address held while waitrequest=1; a tick with no buffered word pulses underrun.
module flash_audio_reader #(
   parameter logic [22:0] BASE       = 23'd0,
   parameter logic [21:0] MAX_OFFSET = 22'h7FFFF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        play,
   input  logic                        reverse,
   input  logic                        restart,
   input  logic                        sample_tick,
   flash_audio_reader_if.master        flash_mem,
   output logic [15:0]                 sample_out,
   output logic                        sample_valid,
   output logic                        underrun
);
   localparam logic [22:0] LAST = BASE + {1'b0, MAX_OFFSET};

   typedef enum logic [1:0] {FETCH, WAIT_DATA, READY} state_t;

   state_t      state, state_n;
   logic [22:0] addr, addr_n;
   logic [22:0] tgt, tgt_n;          // restart target parked while a read is still waiting
   logic [31:0] word, word_n;
   logic        half, half_n;        // 1 once the first half of the word has been played
   logic        word_rev, word_rev_n; // direction the current word started in
   logic        discard, discard_n;  // outstanding read belongs to the pre-restart stream
   logic        rd, rd_n;
   logic [15:0] samp_n;
   logic        samp_vld_n, und_n;
   logic [22:0] restart_addr, step_addr;
   logic        accept, serve;

   assign restart_addr = reverse ? LAST : BASE;
   assign accept       = rd && !flash_mem.waitrequest;
   assign serve        = play && sample_tick && !restart;

   assign flash_mem.read       = rd;
   assign flash_mem.address    = addr;
   assign flash_mem.byteenable = 4'hF;

   // Next word address with wrap-around at both ends of the window.
   always_comb begin
      if (reverse)
         step_addr = (addr == BASE) ? LAST : addr - 23'd1;
      else
         step_addr = (addr == LAST) ? BASE : addr + 23'd1;
   end

   // Next-state, address sequencing and sample selection.
   always_comb begin
      state_n    = state;
      addr_n     = addr;
      tgt_n      = tgt;
      word_n     = word;
      half_n     = half;
      word_rev_n = word_rev;
      discard_n  = discard;
      samp_n     = sample_out;
      samp_vld_n = 1'b0;
      und_n      = 1'b0;

      if (restart)
         half_n = 1'b0;

      case (state)
         FETCH: begin
            if (serve)
               und_n = 1'b1;
            if (accept) begin
               state_n = WAIT_DATA;
               // Read is gone now, so the address may move to the restart target.
               if (restart) begin
                  discard_n = 1'b1;
                  addr_n    = restart_addr;
               end else if (discard) begin
                  addr_n = tgt;
               end
            end else if (restart) begin
               if (rd) begin
                  // Address must stay put until the slave takes the read.
                  discard_n = 1'b1;
                  tgt_n     = restart_addr;
               end else begin
                  addr_n = restart_addr;
               end
            end
         end

         WAIT_DATA: begin
            if (serve)
               und_n = 1'b1;
            if (restart) begin
               discard_n = 1'b1;
               addr_n    = restart_addr;
            end
            if (flash_mem.readdatavalid) begin
               if (discard || restart) begin
                  state_n   = FETCH;
                  discard_n = 1'b0;
               end else begin
                  word_n  = flash_mem.readdata;
                  state_n = READY;
               end
            end
         end

         READY: begin
            if (restart) begin
               state_n = FETCH;
               addr_n  = restart_addr;
            end else if (play && sample_tick) begin
               samp_vld_n = 1'b1;
               if (!half) begin
                  word_rev_n = reverse;
                  samp_n     = reverse ? word[31:16] : word[15:0];
                  half_n     = 1'b1;
               end else begin
                  samp_n  = word_rev ? word[15:0] : word[31:16];
                  half_n  = 1'b0;
                  state_n = FETCH;
                  addr_n  = step_addr;
               end
            end
         end

         default: state_n = FETCH;
      endcase

      rd_n = (state_n == FETCH);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= FETCH;
         addr         <= BASE;
         tgt          <= BASE;
         word         <= 32'd0;
         half         <= 1'b0;
         word_rev     <= 1'b0;
         discard      <= 1'b0;
         rd           <= 1'b0;
         sample_out   <= 16'd0;
         sample_valid <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         state        <= state_n;
         addr         <= addr_n;
         tgt          <= tgt_n;
         word         <= word_n;
         half         <= half_n;
         word_rev     <= word_rev_n;
         discard      <= discard_n;
         rd           <= rd_n;
         sample_out   <= samp_n;
         sample_valid <= samp_vld_n;
         underrun     <= und_n;
      end
   end
endmodule

// File: tb/tb_flash_audio_reader.sv
// Scoreboard bench for flash_audio_reader: directed play/reverse/restart/pause sequences.
// A flash model answers reads with programmable stall and latency.
// Expected samples and read addresses are queued by the stimulus and popped by monitors.
module tb_flash_audio_reader;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        play = 1'b0;
   logic        reverse = 1'b0;
   logic        restart = 1'b0;
   logic        sample_tick = 1'b0;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic        underrun;

   flash_audio_reader_if bus();

   flash_audio_reader #(.BASE(23'd0), .MAX_OFFSET(22'd3)) dut (
      .clk         (clk),
      .reset       (reset),
      .play        (play),
      .reverse     (reverse),
      .restart     (restart),
      .sample_tick (sample_tick),
      .flash_mem   (bus),
      .sample_out  (sample_out),
      .sample_valid(sample_valid),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          und;
      logic [15:0] val;
   } ev_t;

   ev_t         exp_ev[$];
   logic [22:0] exp_addr[$];
   logic [31:0] mem [0:3];
   int          checks = 0;
   int          passed = 0;
   int          ev_seen = 0;
   int          stall_cfg = 3;
   int          lat_cfg = 2;
   int          stall_cnt = 0;
   int          lat_cnt = 0;
   logic [22:0] pend = '0;
   ev_t         mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
   endtask

   task automatic push_s(input logic [15:0] v);
      ev_t e;
      e.und = 1'b0;
      e.val = v;
      exp_ev.push_back(e);
   endtask

   task automatic push_u(input logic [15:0] v);
      ev_t e;
      e.und = 1'b1;
      e.val = v;
      exp_ev.push_back(e);
   endtask

   // Word is READY on entry; plays both halves and waits for the next word.
   task automatic serve_word(input logic [15:0] a, input logic [15:0] b, input logic [22:0] nxt);
      push_s(a);
      push_s(b);
      exp_addr.push_back(nxt);
      tick();
      cyc(2);
      tick();
      cyc(12);
   endtask

   // Flash slave: stall each read stall_cfg cycles, return data lat_cfg cycles after accept.
   initial begin
      bus.waitrequest   = 1'b1;
      bus.readdatavalid = 1'b0;
      bus.readdata      = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.readdatavalid = 1'b0;
         if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
               bus.readdatavalid = 1'b1;
               bus.readdata      = mem[pend[1:0]];
            end
         end
         if (!bus.read) begin
            bus.waitrequest = 1'b1;
            stall_cnt       = stall_cfg;
         end else if (stall_cnt > 0) begin
            bus.waitrequest = 1'b1;
            stall_cnt--;
         end else begin
            bus.waitrequest = 1'b0;
            pend            = bus.address;
            lat_cnt         = lat_cfg;
            if (exp_addr.size() == 0) begin
               checks++;
               $display("FAIL read_addr: read accepted at %h, none expected", bus.address);
            end else begin
               chk("read_addr", {9'd0, bus.address}, {9'd0, exp_addr.pop_front()});
            end
         end
      end
   end

   // Output monitor: every sample_valid/underrun pulse must match the next queued event.
   initial begin
      forever begin
         @(negedge clk);
         if (sample_valid || underrun) begin
            ev_seen++;
            if (sample_valid && underrun) begin
               checks++;
               $display("FAIL event_kind: sample_valid and underrun both high");
            end else if (exp_ev.size() == 0) begin
               checks++;
               $display("FAIL event_extra: valid=%b underrun=%b sample=%h, none expected",
                        sample_valid, underrun, sample_out);
            end else begin
               mon_e = exp_ev.pop_front();
               chk("event_kind_underrun", {31'd0, underrun}, {31'd0, mon_e.und});
               chk("sample_out", {16'd0, sample_out}, {16'd0, mon_e.val});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int rd_seen;
      int ev_before;
      mem[0] = 32'hBBBB_AAAA;
      mem[1] = 32'h2222_1111;
      mem[2] = 32'h4444_3333;
      mem[3] = 32'h6666_5555;

      // Reset state.
      cyc(2);
      chk("rst_read", {31'd0, bus.read}, 32'd0);
      chk("rst_addr", {9'd0, bus.address}, 32'd0);
      chk("rst_byteenable", {28'd0, bus.byteenable}, 32'hF);
      chk("rst_sample_out", {16'd0, sample_out}, 32'd0);
      chk("rst_valid", {31'd0, sample_valid}, 32'd0);
      chk("rst_underrun", {31'd0, underrun}, 32'd0);
      exp_addr.push_back(23'd0);
      reset = 1'b1;
      cyc(1);
      chk("first_read", {31'd0, bus.read}, 32'd1);
      chk("first_addr", {9'd0, bus.address}, 32'd0);
      play = 1'b1;
      cyc(12);

      // Forward play of word 0, then forward through the window with wrap.
      serve_word(16'hAAAA, 16'hBBBB, 23'd1);
      serve_word(16'h1111, 16'h2222, 23'd2);
      serve_word(16'h3333, 16'h4444, 23'd3);
      serve_word(16'h5555, 16'h6666, 23'd0);

      // Reverse: upper half first, address wraps from BASE to the last word.
      reverse = 1'b1;
      serve_word(16'hBBBB, 16'hAAAA, 23'd3);

      // Word 3 in reverse, then restart (with a coincident tick) while word 2 is in flight.
      push_s(16'h6666);
      push_s(16'h5555);
      exp_addr.push_back(23'd2);
      exp_addr.push_back(23'd0);
      tick();
      cyc(2);
      tick();
      cyc(4);
      reverse     = 1'b0;
      restart     = 1'b1;
      sample_tick = 1'b1;
      cyc();
      restart     = 1'b0;
      sample_tick = 1'b0;
      cyc(12);

      // Word 0 after restart, then a tick right after the word is consumed.
      push_s(16'hAAAA);
      push_s(16'hBBBB);
      push_u(16'hBBBB);
      exp_addr.push_back(23'd1);
      tick();
      cyc(2);
      tick();
      tick();
      cyc(12);

      // Paused with word 1 buffered: ticks ignored, no reads.
      play      = 1'b0;
      rd_seen   = 0;
      ev_before = ev_seen;
      repeat (5) begin
         tick();
         if (bus.read) rd_seen++;
         cyc(1);
         if (bus.read) rd_seen++;
      end
      chk("paused_no_read", rd_seen, 32'd0);
      chk("paused_no_event", ev_seen - ev_before, 32'd0);
      play = 1'b1;
      push_s(16'h1111);
      tick();
      cyc(3);

      // Finish word 1, then reset while the next read is stalled.
      stall_cfg = 6;
      push_s(16'h2222);
      tick();
      chk("prefetch_read", {31'd0, bus.read}, 32'd1);
      chk("prefetch_addr", {9'd0, bus.address}, 32'd2);
      cyc(1);
      #2;
      reset = 1'b0;
      #1;
      chk("midreset_read", {31'd0, bus.read}, 32'd0);
      chk("midreset_addr", {9'd0, bus.address}, 32'd0);
      cyc(2);
      stall_cfg = 3;
      exp_addr.push_back(23'd0);
      reset = 1'b1;
      cyc(1);
      chk("rerelease_read", {31'd0, bus.read}, 32'd1);
      chk("rerelease_addr", {9'd0, bus.address}, 32'd0);
      cyc(12);
      push_s(16'hAAAA);
      tick();
      cyc(3);

      chk("events_drained", exp_ev.size(), 32'd0);
      chk("reads_drained", exp_addr.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
